hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl_if.sv | 41 ++++
 rtl/hex_display_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_hex_display_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl_if
//
// Purpose: groups the load handshake of hex_display_ctrl into one bundle.
//          The producer presents a packed hex number on 'value'. It raises
//          'load_valid' to ask the display to capture it. The display
//          answers with 'load_ready' when it can take a new number this cycle.
//
// Parameter:
//   NUM_DIGITS  number of hex digits carried on 'value' (1..8)
//
// Signals:
//   value       [4*NUM_DIGITS-1:0]  number to show, digit 0 in bits [3:0]
//   load_valid  producer request to capture 'value'
//   load_ready  display can accept a load this cycle
//
// Modports:
//   master      producer side (drives value/load_valid)
//   slave       display side  (drives load_ready)
// ---------------------------------------------------------------------------
interface hex_display_ctrl_if #(
   parameter int NUM_DIGITS = 6
);

   logic [4*NUM_DIGITS-1:0] value;
   logic                    load_valid;
   logic                    load_ready;

   modport master (
      output value,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  value,
      input  load_valid,
      output load_ready
   );

endinterface

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//
// Purpose: drives NUM_DIGITS seven-segment digits (active-low) from a packed
//          hex number. The block holds one shared 4-to-7 decoder. A small
//          FSM (IDLE/UPDATE) walks that decoder across the digits,
//          most-significant digit first, one digit per clock. A free-running
//          counter produces a blink phase. The phase, and a separate blank
//          input, can force the whole display dark without touching the
//          stored segment data.
//
// Parameters:
//   NUM_DIGITS  number of digits driven (1..8)
//   BLINK_DIV   blink half-period in clock cycles (>= 2)
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   load        hex_display_ctrl_if.slave (value, load_valid, load_ready)
//   blink_en    enables periodic blanking of all digits
//   blank       forces all segments off, combinationally
//   hex         [7*NUM_DIGITS-1:0] active-low segments, digit i in
//               hex[7i+6:7i], bit 0 = segment a ... bit 6 = segment g
//
// Build option:
//   HEX_DISPLAY_CTRL_LZB_EN  when defined, leading zeros of a load are
//                            written as blank digits (digit 0 always shown).
//                            Update timing is the same with or without it.
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   hex_display_ctrl_if.slave       load,
   input  logic                    blink_en,
   input  logic                    blank,
   output logic [7*NUM_DIGITS-1:0] hex
);

   // Index is sized for the largest legal display (8 digits) so the same
   // compare logic works for every NUM_DIGITS without zero-width corner cases.
   localparam int IW = 3;
   localparam logic [IW-1:0] TOP_INDEX = IW'(NUM_DIGITS - 1);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef enum logic {
      IDLE   = 1'b0,
      UPDATE = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic                    ready;
   logic [IW-1:0]           index_q;
   logic [4*NUM_DIGITS-1:0] shadow_q;
   logic [6:0]              seg_q [NUM_DIGITS];
   logic [3:0]              cur_digit;
   logic [6:0]              seg_dec;
   logic [6:0]              seg_wr;
   logic [7*NUM_DIGITS-1:0] seg_flat;
   logic [CW-1:0]           blink_cnt_q;
   logic                    blink_phase_q;

   // Standard active-low hex font, bits ordered g..a.
   function automatic logic [6:0] decode_hex(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // State register. Reset always lands in IDLE. This also abandons an
   // update that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake. Ready is held low while reset is
   // asserted, so a producer never sees an accept that the reset then drops.
   // In UPDATE the request is simply not looked at: nothing is captured or
   // queued.
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      case (state_q)
         IDLE: begin
            ready = ~rst;
            if (load.load_valid) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            if (index_q == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign load.load_ready = ready;

   // Select the shadow digit that the current index points at. This single
   // nibble feeds the one shared decoder.
   always_comb begin
      cur_digit = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index_q == IW'(i)) begin
            cur_digit = shadow_q[4*i +: 4];
         end
      end
   end

   assign seg_dec = decode_hex(cur_digit);

`ifdef HEX_DISPLAY_CTRL_LZB_EN
   logic lead_zero_q;

   // Blank a zero digit when every digit already written in this load was
   // also zero. Digits are written from the top down, so one flag is enough.
   // The flag drops at the first non-zero digit. The units digit is never
   // blanked, so a value of 0 still shows a single "0".
   assign seg_wr = (lead_zero_q && (cur_digit == 4'h0) && (index_q != '0))
                   ? SEG_OFF : seg_dec;

   // Leading-zero tracker. It is re-armed on every accepted load and cleared
   // by the first non-zero digit that the update walk reaches.
   always_ff @(posedge clk) begin
      if (rst) begin
         lead_zero_q <= 1'b1;
      end else if (state_q == IDLE) begin
         if (load.load_valid) begin
            lead_zero_q <= 1'b1;
         end
      end else if (cur_digit != 4'h0) begin
         lead_zero_q <= 1'b0;
      end
   end
`else
   assign seg_wr = seg_dec;
`endif

   // Load capture and digit walk.
   // The accepting edge snapshots 'value' into the shadow register, so later
   // changes on the bus cannot tear the displayed number. Each UPDATE cycle
   // then writes one segment register, starting with the most-significant
   // digit. Digits not yet reached keep showing the previous number. The
   // index is parked back at the top digit once digit 0 is written.
   always_ff @(posedge clk) begin
      if (rst) begin
         index_q  <= TOP_INDEX;
         shadow_q <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_q[i] <= SEG_OFF;
         end
      end else if (state_q == IDLE) begin
         if (load.load_valid) begin
            shadow_q <= load.value;
            index_q  <= TOP_INDEX;
         end
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index_q == IW'(i)) begin
               seg_q[i] <= seg_wr;
            end
         end
         if (index_q == '0) begin
            index_q <= TOP_INDEX;
         end else begin
            index_q <= index_q - 1'b1;
         end
      end
   end

   // Free-running blink timebase. The phase flips once per BLINK_DIV cycles.
   // blink_en only gates the output, so switching it on and off never
   // disturbs the rhythm.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q   <= blink_cnt_q + 1'b1;
      end
   end

   // Output stage. The stored segments are flattened into the bus. blank
   // wins over everything, and the blink phase only darkens the display when
   // blinking is enabled. Neither path touches stored state.
   always_comb begin
      seg_flat = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         seg_flat[7*i +: 7] = seg_q[i];
      end
      if (blank || (blink_en && blink_phase_q)) begin
         hex = '1;
      end else begin
         hex = seg_flat;
      end
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl
//
// Purpose: self-checking bench for hex_display_ctrl with NUM_DIGITS=6 and
//          BLINK_DIV=4. A reference model tracks, as a timeline, the number
//          on show, the number being rolled in, how many digits of it are
//          visible so far, and the blink phase (taken from the count of edges
//          since reset). Directed sequences come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_hex_display_ctrl;

   localparam int NUM_DIGITS = 6;
   localparam int BLINK_DIV  = 4;
   localparam int HW         = 7 * NUM_DIGITS;
   localparam int VW         = 4 * NUM_DIGITS;

   logic          clk = 1'b0;
   logic          rst;
   logic          blink_en;
   logic          blank;
   logic [HW-1:0] hex;

   hex_display_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) load_bus ();

   hex_display_ctrl #(
      .NUM_DIGITS(NUM_DIGITS),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load_bus),
      .blink_en(blink_en),
      .blank   (blank),
      .hex     (hex)
   );

   always #5 clk = ~clk;

   // Active-low hex font, bits g..a, indexed by digit value.
   logic [6:0] seg_table [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int          edges_since_reset = 0;
   bit          busy              = 1'b0;
   int          shown_digits      = 0;
   logic [HW-1:0] disp_seg        = '1;
   logic [HW-1:0] old_seg         = '1;
   logic [HW-1:0] new_seg         = '1;

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time,
                  observed, expected);
      end
   endtask

   // Builds the full segment picture that a load of 'v' should leave behind.
   function automatic logic [HW-1:0] render(input logic [VW-1:0] v);
      logic [HW-1:0] r;
      logic [3:0]    d;
`ifdef HEX_DISPLAY_CTRL_LZB_EN
      bit            leading;
      leading = 1'b1;
`endif
      r = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         r[7*i +: 7] = seg_table[d];
`ifdef HEX_DISPLAY_CTRL_LZB_EN
         if (leading && d == 4'h0 && i != 0) begin
            r[7*i +: 7] = 7'b1111111;
         end
         if (d != 4'h0) begin
            leading = 1'b0;
         end
`endif
      end
      return r;
   endfunction

   // Drives one cycle of inputs, advances the model across the edge, and
   // then checks load_ready and hex against the model.
   task automatic applyStimulus(input logic r, input logic lv,
                                input logic [VW-1:0] v, input logic be,
                                input logic bl);
      logic [HW-1:0] exp_disp;
      logic [HW-1:0] exp_hex;
      logic          exp_ready;
      bit            phase;
      rst                 = r;
      load_bus.load_valid = lv;
      load_bus.value      = v;
      blink_en            = be;
      blank               = bl;
      @(posedge clk);
      if (r) begin
         edges_since_reset = 0;
         busy              = 1'b0;
         shown_digits      = 0;
         disp_seg          = '1;
      end else begin
         edges_since_reset++;
         if (busy) begin
            shown_digits++;
            if (shown_digits == NUM_DIGITS) begin
               busy     = 1'b0;
               disp_seg = new_seg;
            end
         end else if (lv) begin
            busy         = 1'b1;
            shown_digits = 0;
            old_seg      = disp_seg;
            new_seg      = render(v);
         end
      end
      #1;
      exp_disp = disp_seg;
      if (busy) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            exp_disp[7*i +: 7] = (i >= NUM_DIGITS - shown_digits)
                                 ? new_seg[7*i +: 7] : old_seg[7*i +: 7];
         end
      end
      phase     = ((edges_since_reset / BLINK_DIV) % 2) == 1;
      exp_hex   = (bl || (be && phase)) ? '1 : exp_disp;
      exp_ready = !busy && !r;
      checkOutput("load_ready", 64'(load_bus.load_ready), 64'(exp_ready));
      checkOutput("hex", 64'(hex), 64'(exp_hex));
   endtask

   initial begin
      logic [VW-1:0] rv;
      logic [HW-1:0] lit;

      // Two reset cycles, with a load request that must be ignored.
      applyStimulus(1'b1, 1'b1, 24'h123456, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0);
      checkOutput("hex_in_reset", 64'(hex), 64'(HW'('1)));
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 64'(load_bus.load_ready), 64'd1);
      applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);

      // Directed load and literal check of the finished picture.
      applyStimulus(1'b0, 1'b1, 24'h12AB8F, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);
      end
      lit = {7'b1111001, 7'b0100100, 7'b0001000,
             7'b0000011, 7'b0000000, 7'b0001110};
      checkOutput("hex_12ab8f", 64'(hex), 64'(lit));

      // Leading zeros of a small value.
      applyStimulus(1'b0, 1'b1, 24'h00000A, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);
      end
`ifdef HEX_DISPLAY_CTRL_LZB_EN
      lit = {{5{7'b1111111}}, 7'b0001000};
`else
      lit = {{5{7'b1000000}}, 7'b0001000};
`endif
      checkOutput("hex_00000a", 64'(hex), 64'(lit));

      // Blink on a stable value, then blank pulses on top of it.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 24'h000000, 1'b1, i[0]);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1);
      end

      // load_valid held high with a changing value across several updates.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, VW'(24'h314159 + i * 24'h010101),
                       1'b0, 1'b0);
      end

      // Reset on the third UPDATE cycle must leave no stale digits.
      applyStimulus(1'b0, 1'b1, 24'hFEDCBA, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0);
      checkOutput("hex_after_abort", 64'(hex), 64'(HW'('1)));
      applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rv = VW'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
         applyStimulus($urandom_range(0, 49) == 0,
                       $urandom_range(0, 3) == 0,
                       rv,
                       $urandom_range(0, 1) == 1,
                       $urandom_range(0, 9) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, failures);
      $finish;
   end

endmodule
